// File: rtl/rs_multi_bank.sv
// Multi-bank reservation station: one allocation port, N_CDB wakeup buses, oldest-ready issue per bank.
// Define RS_FLUSH_EN to add the flush_i port, which empties every bank at the next clock edge.
module rs_multi_bank #(
    parameter int N_FU  = 3,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32,
    parameter int N_CDB = 1,
    localparam int FU_W = (N_FU > 1) ? $clog2(N_FU) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
`ifdef RS_FLUSH_EN
    input  logic                    flush_i,
`endif
    input  logic                    alloc_valid_i,
    input  logic [FU_W-1:0]         alloc_fu_i,
    output logic                    alloc_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         inst_i,
    input  logic [TAG_W-1:0]        prs1_addr_i,
    input  logic [TAG_W-1:0]        prs2_addr_i,
    input  logic [TAG_W-1:0]        prd_addr_i,
    input  logic                    prs1_valid_i,
    input  logic                    prs2_valid_i,
    input  logic [N_CDB-1:0]        cdb_en_i,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag_i,
    output logic [N_FU-1:0]         fu_free_o,
    output logic [N_FU-1:0]         issue_valid_o,
    input  logic [N_FU-1:0]         issue_ready_i,
    output logic [N_FU*XLEN-1:0]    issue_pc_o,
    output logic [N_FU*XLEN-1:0]    issue_inst_o,
    output logic [N_FU*TAG_W-1:0]   issue_prs1_addr_o,
    output logic [N_FU*TAG_W-1:0]   issue_prs2_addr_o,
    output logic [N_FU*TAG_W-1:0]   issue_prd_addr_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic cdb_hit(
        input logic [TAG_W-1:0]       tag,
        input logic [N_CDB-1:0]       en,
        input logic [N_CDB*TAG_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_CDB; k++) begin
            if (en[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic            flush;
    logic            alloc_legal;
    logic            alloc_fire;
    logic            alloc_rdy1;
    logic            alloc_rdy2;
    logic [N_FU-1:0] full;

`ifdef RS_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Occupancy is taken from registered state only, so a same-cycle issue never frees a slot.
    assign alloc_legal = ({1'b0, alloc_fu_i} < (FU_W+1)'(N_FU));

    always_comb begin
        alloc_ready_o = 1'b0;
        for (int b = 0; b < N_FU; b++) begin
            if (alloc_legal && (alloc_fu_i == FU_W'(b))) begin
                alloc_ready_o = ~full[b];
            end
        end
    end

    assign fu_free_o  = ~full;
    assign alloc_fire = alloc_valid_i & alloc_ready_o;
    assign alloc_rdy1 = prs1_valid_i | cdb_hit(prs1_addr_i, cdb_en_i, cdb_tag_i);
    assign alloc_rdy2 = prs2_valid_i | cdb_hit(prs2_addr_i, cdb_en_i, cdb_tag_i);

    generate
        for (genvar gi = 0; gi < N_FU; gi++) begin : g_bank
            logic [DEPTH-1:0] valid_reg, valid_next;
            logic [DEPTH-1:0] rdy1_reg, rdy1_next;
            logic [DEPTH-1:0] rdy2_reg, rdy2_next;
            // age_reg[i][j] set means entry i is older than entry j
            logic [DEPTH-1:0] age_reg  [DEPTH];
            logic [DEPTH-1:0] age_next [DEPTH];

            logic [XLEN-1:0]  pc_mem   [DEPTH];
            logic [XLEN-1:0]  inst_mem [DEPTH];
            logic [TAG_W-1:0] prs1_mem [DEPTH];
            logic [TAG_W-1:0] prs2_mem [DEPTH];
            logic [TAG_W-1:0] prd_mem  [DEPTH];

            logic [DEPTH-1:0] hit1, hit2;
            logic [DEPTH-1:0] ready_vec;
            logic [DEPTH-1:0] oldest;
            logic [IDX_W-1:0] free_idx;
            logic             bank_alloc;
            logic             issue_fire;

            logic [XLEN-1:0]  sel_pc, sel_inst;
            logic [TAG_W-1:0] sel_prs1, sel_prs2, sel_prd;

            assign full[gi]           = &valid_reg;
            assign bank_alloc         = alloc_fire & (alloc_fu_i == FU_W'(gi)) & ~flush;
            assign ready_vec          = valid_reg & rdy1_reg & rdy2_reg;
            assign issue_valid_o[gi]  = |ready_vec;
            assign issue_fire         = issue_valid_o[gi] & issue_ready_i[gi] & ~flush;

            always_comb begin
                hit1 = '0;
                hit2 = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    hit1[i] = cdb_hit(prs1_mem[i], cdb_en_i, cdb_tag_i);
                    hit2[i] = cdb_hit(prs2_mem[i], cdb_en_i, cdb_tag_i);
                end
            end

            // Lowest-index free slot wins
            always_comb begin
                free_idx = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (!valid_reg[i]) begin
                        free_idx = IDX_W'(i);
                    end
                end
            end

            always_comb begin
                oldest = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    oldest[i] = ready_vec[i];
                    for (int j = 0; j < DEPTH; j++) begin
                        if ((j != i) && ready_vec[j] && !age_reg[i][j]) begin
                            oldest[i] = 1'b0;
                        end
                    end
                end
            end

            always_comb begin
                sel_pc   = '0;
                sel_inst = '0;
                sel_prs1 = '0;
                sel_prs2 = '0;
                sel_prd  = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (oldest[i]) begin
                        sel_pc   = pc_mem[i];
                        sel_inst = inst_mem[i];
                        sel_prs1 = prs1_mem[i];
                        sel_prs2 = prs2_mem[i];
                        sel_prd  = prd_mem[i];
                    end
                end
            end

            always_comb begin
                valid_next = valid_reg;
                rdy1_next  = rdy1_reg | (valid_reg & hit1);
                rdy2_next  = rdy2_reg | (valid_reg & hit2);
                age_next   = age_reg;
                if (issue_fire) begin
                    valid_next = valid_next & ~oldest;
                end
                if (bank_alloc) begin
                    valid_next[free_idx] = 1'b1;
                    rdy1_next[free_idx]  = alloc_rdy1;
                    rdy2_next[free_idx]  = alloc_rdy2;
                    // New entry is younger than every entry currently held
                    age_next[free_idx]   = '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        age_next[j][free_idx] = valid_reg[j];
                    end
                end
                if (flush) begin
                    valid_next = '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        age_next[i] = '0;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    valid_reg <= '0;
                    rdy1_reg  <= '0;
                    rdy2_reg  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        age_reg[i] <= '0;
                    end
                end else begin
                    valid_reg <= valid_next;
                    rdy1_reg  <= rdy1_next;
                    rdy2_reg  <= rdy2_next;
                    age_reg   <= age_next;
                end
            end

            // Payload is only observed behind valid, so it needs no reset
            always_ff @(posedge clk_i) begin
                if (bank_alloc) begin
                    pc_mem[free_idx]   <= pc_i;
                    inst_mem[free_idx] <= inst_i;
                    prs1_mem[free_idx] <= prs1_addr_i;
                    prs2_mem[free_idx] <= prs2_addr_i;
                    prd_mem[free_idx]  <= prd_addr_i;
                end
            end

            assign issue_pc_o[gi*XLEN +: XLEN]          = sel_pc;
            assign issue_inst_o[gi*XLEN +: XLEN]        = sel_inst;
            assign issue_prs1_addr_o[gi*TAG_W +: TAG_W] = sel_prs1;
            assign issue_prs2_addr_o[gi*TAG_W +: TAG_W] = sel_prs2;
            assign issue_prd_addr_o[gi*TAG_W +: TAG_W]  = sel_prd;
        end
    endgenerate

endmodule

// File: tb/tb_rs_multi_bank.sv
// Scoreboard bench for rs_multi_bank: the driver keeps an age-ordered list per bank and queues
// expectations; a negedge monitor pops and compares against what the DUT presents.
module tb_rs_multi_bank;
    localparam int N_FU  = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int XLEN  = 32;
    localparam int N_CDB = 1;
    localparam int FU_W  = 2;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   a_valid;
    logic [FU_W-1:0]        a_fu;
    logic                   a_ready;
    logic [XLEN-1:0]        pc, inst;
    logic [TAG_W-1:0]       s1, s2, d;
    logic                   v1, v2;
    logic [N_CDB-1:0]       cdb_en;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_FU-1:0]        fu_free, iss_valid, iss_ready;
    logic [N_FU*XLEN-1:0]   iss_pc, iss_inst;
    logic [N_FU*TAG_W-1:0]  iss_s1, iss_s2, iss_d;
`ifdef RS_FLUSH_EN
    logic                   flush = 1'b0;
`endif

    rs_multi_bank #(.N_FU(N_FU), .DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .N_CDB(N_CDB)) dut (
        .clk_i(clk),
        .reset_ni(reset_n),
`ifdef RS_FLUSH_EN
        .flush_i(flush),
`endif
        .alloc_valid_i(a_valid),
        .alloc_fu_i(a_fu),
        .alloc_ready_o(a_ready),
        .pc_i(pc),
        .inst_i(inst),
        .prs1_addr_i(s1),
        .prs2_addr_i(s2),
        .prd_addr_i(d),
        .prs1_valid_i(v1),
        .prs2_valid_i(v2),
        .cdb_en_i(cdb_en),
        .cdb_tag_i(cdb_tag),
        .fu_free_o(fu_free),
        .issue_valid_o(iss_valid),
        .issue_ready_i(iss_ready),
        .issue_pc_o(iss_pc),
        .issue_inst_o(iss_inst),
        .issue_prs1_addr_o(iss_s1),
        .issue_prs2_addr_o(iss_s2),
        .issue_prd_addr_o(iss_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  pc, inst;
        logic [TAG_W-1:0] s1, s2, d;
        bit               r1, r2;
    } ent_t;
    typedef struct {
        int               bank;
        logic [XLEN-1:0]  pc, inst;
        logic [TAG_W-1:0] s1, s2, d;
    } ret_t;
    typedef struct {
        logic [N_FU-1:0] v, free;
        logic            ar;
    } stat_t;

    // Per bank, entries kept in arrival order: index 0 is the oldest.
    ent_t  mdl  [N_FU][DEPTH];
    int    mcnt [N_FU];
    ret_t  ret_q[$];
    stat_t stat_q[$];
    int    tests = 0;
    int    fails = 0;

    function automatic bit tb_hit(logic [TAG_W-1:0] t);
        for (int k = 0; k < N_CDB; k++)
            if (cdb_en[k] && cdb_tag[k*TAG_W +: TAG_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int oldest_ready(int b);
        for (int i = 0; i < mcnt[b]; i++)
            if (mdl[b][i].r1 && mdl[b][i].r2) return i;
        return -1;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: predict from current model state and inputs, then apply the edge.
    task automatic step();
        stat_t st;
        ret_t  rr;
        ent_t  e;
        int    sel [N_FU];
        int    fu;
        bit    fl;
        fl = 1'b0;
`ifdef RS_FLUSH_EN
        fl = flush;
`endif
        if (!reset_n) for (int b = 0; b < N_FU; b++) mcnt[b] = 0;
        fu = int'(a_fu);
        for (int b = 0; b < N_FU; b++) begin
            sel[b]     = oldest_ready(b);
            st.v[b]    = (sel[b] >= 0);
            st.free[b] = (mcnt[b] < DEPTH);
        end
        st.ar = (fu < N_FU) ? (mcnt[fu] < DEPTH) : 1'b0;
        stat_q.push_back(st);
        for (int b = 0; b < N_FU; b++) begin
            if (sel[b] >= 0 && iss_ready[b] && !fl) begin
                rr.bank = b;
                rr.pc = mdl[b][sel[b]].pc;  rr.inst = mdl[b][sel[b]].inst;
                rr.s1 = mdl[b][sel[b]].s1;  rr.s2 = mdl[b][sel[b]].s2;  rr.d = mdl[b][sel[b]].d;
                ret_q.push_back(rr);
            end
        end
        @(posedge clk);
        if (reset_n) begin
            if (fl) begin
                for (int b = 0; b < N_FU; b++) mcnt[b] = 0;
            end else begin
                for (int b = 0; b < N_FU; b++) begin
                    if (sel[b] >= 0 && iss_ready[b]) begin
                        for (int i = sel[b]; i < mcnt[b] - 1; i++) mdl[b][i] = mdl[b][i+1];
                        mcnt[b]--;
                    end
                    for (int i = 0; i < mcnt[b]; i++) begin
                        if (tb_hit(mdl[b][i].s1)) mdl[b][i].r1 = 1'b1;
                        if (tb_hit(mdl[b][i].s2)) mdl[b][i].r2 = 1'b1;
                    end
                end
                if (a_valid && st.ar) begin
                    e.pc = pc;  e.inst = inst;  e.s1 = s1;  e.s2 = s2;  e.d = d;
                    e.r1 = v1 | tb_hit(s1);
                    e.r2 = v2 | tb_hit(s2);
                    mdl[fu][mcnt[fu]] = e;
                    mcnt[fu]++;
                end
            end
        end
        #1;
    endtask

    task automatic set_alloc(bit v, int fu, logic [XLEN-1:0] p, logic [TAG_W-1:0] ta,
                             logic [TAG_W-1:0] tb, logic [TAG_W-1:0] td, bit va, bit vb);
        a_valid = v;  a_fu = FU_W'(fu);  pc = p;  inst = $urandom;
        s1 = ta;  s2 = tb;  d = td;  v1 = va;  v2 = vb;
    endtask

    task automatic set_cdb(bit en, logic [TAG_W-1:0] t);
        cdb_en = '0;
        cdb_tag = '0;
        cdb_en[0] = en;
        cdb_tag[TAG_W-1:0] = t;
    endtask

    // Monitor
    initial begin
        stat_t st;
        ret_t  r;
        bit    fl;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                st = stat_q.pop_front();
                fl = 1'b0;
`ifdef RS_FLUSH_EN
                fl = flush;
`endif
                chk("issue_valid", 128'(iss_valid), 128'(st.v));
                chk("fu_free", 128'(fu_free), 128'(st.free));
                chk("alloc_ready", 128'(a_ready), 128'(st.ar));
                for (int b = 0; b < N_FU; b++) begin
                    if (iss_valid[b] && iss_ready[b] && !fl) begin
                        if (ret_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_issue: bank %0d pc %0h, expected none", b,
                                     iss_pc[b*XLEN +: XLEN]);
                        end else begin
                            r = ret_q.pop_front();
                            chk("issue_bank", 128'(b), 128'(r.bank));
                            chk("issue_payload",
                                {iss_pc[b*XLEN +: XLEN], iss_inst[b*XLEN +: XLEN],
                                 iss_s1[b*TAG_W +: TAG_W], iss_s2[b*TAG_W +: TAG_W],
                                 iss_d[b*TAG_W +: TAG_W]},
                                {r.pc, r.inst, r.s1, r.s2, r.d});
                        end
                    end else if (!iss_valid[b]) begin
                        chk("idle_payload",
                            {iss_pc[b*XLEN +: XLEN], iss_inst[b*XLEN +: XLEN],
                             iss_s1[b*TAG_W +: TAG_W], iss_s2[b*TAG_W +: TAG_W],
                             iss_d[b*TAG_W +: TAG_W]}, 128'd0);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        reset_n = 1'b0;
        iss_ready = '0;
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        set_cdb(0, '0);
        for (int b = 0; b < N_FU; b++) mcnt[b] = 0;
        @(posedge clk);
        #1;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Wakeup: sources arrive on the CDB two and four cycles after allocation
        iss_ready = 3'b111;
        set_alloc(1, 0, 32'h100, 5'd2, 5'd3, 5'd9, 0, 0);
        step();
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        step();
        set_cdb(1, 5'd2); step();
        set_cdb(0, '0);   step();
        set_cdb(1, 5'd3); step();
        set_cdb(0, '0);   step();
        step();

        // Age order: fill bank 1 while stalled, then drain oldest first
        iss_ready = 3'b101;
        for (int k = 0; k < DEPTH; k++) begin
            set_alloc(1, 1, 32'h10 + 32'(4 * k), 5'd1, 5'd1, 5'(k), 1, 1);
            step();
        end
        set_alloc(1, 1, 32'h20, 5'd1, 5'd1, 5'd7, 1, 1);
        step();
        step();
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        iss_ready = 3'b111;
        for (int k = 0; k < DEPTH + 1; k++) step();

        // Same-cycle capture of a CDB broadcast during allocation
        set_alloc(1, 0, 32'h200, 5'd7, 5'd4, 5'd5, 0, 1);
        set_cdb(1, 5'd7);
        step();
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        set_cdb(0, '0);
        step();
        step();

        // Full bank: issue and allocate together, the allocation must wait a cycle
        iss_ready = 3'b011;
        for (int k = 0; k < DEPTH; k++) begin
            set_alloc(1, 2, 32'h300 + 32'(4 * k), 5'd0, 5'd0, 5'(k), 1, 1);
            step();
        end
        iss_ready = 3'b111;
        set_alloc(1, 2, 32'h340, 5'd0, 5'd0, 5'd20, 1, 1);
        step();
        iss_ready = 3'b011;
        set_alloc(1, 2, 32'h344, 5'd0, 5'd0, 5'd21, 1, 1);
        step();
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        step();
        iss_ready = 3'b111;
        for (int k = 0; k < DEPTH + 1; k++) step();

        // Illegal bank index is never ready
        set_alloc(1, 3, 32'h400, 5'd0, 5'd0, 5'd0, 1, 1);
        step();

`ifdef RS_FLUSH_EN
        iss_ready = 3'b000;
        for (int k = 0; k < 2 * N_FU; k++) begin
            set_alloc(1, k % N_FU, 32'h500 + 32'(4 * k), 5'd0, 5'd0, 5'(k), 1, 1);
            step();
        end
        iss_ready = 3'b111;
        flush = 1'b1;
        set_alloc(1, 0, 32'h600, 5'd0, 5'd0, 5'd1, 1, 1);
        step();
        flush = 1'b0;
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        step();
        step();
`endif

        // Randomised traffic with a reset asserted in the middle
        for (int n = 0; n < 400; n++) begin
            set_alloc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            set_cdb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
            for (int b = 0; b < N_FU; b++) iss_ready[b] = ($urandom_range(0, 9) < 6);
            reset_n = !(n == 200);
            step();
        end

        reset_n = 1'b1;
        set_alloc(0, 0, '0, '0, '0, '0, 0, 0);
        set_cdb(0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("status_queue_drained", 128'(stat_q.size()), 128'd0);
        chk("issue_queue_drained", 128'(ret_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
